// File: rtl/ps2_scan_ctrl.sv
// PS/2 Set-2 scan-code sequencer: folds E0/F0 prefixes into one key event,
// holds it behind a valid/ack handshake and gates the byte receiver meanwhile.
module ps2_scan_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 500000,
   parameter int unsigned TW          = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_en,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_release,
   output logic       key_ext,
   input  logic       key_ack,
   output logic       err_tick,
   output logic       overrun_tick
);

   typedef enum logic [2:0] {StIdle, StBrk, StExt, StExtBrk, StHold} state_e;

   localparam logic [TW-1:0] WdLast = TW'(TIMEOUT_CYC - 1);

   state_e        state_q, state_d;
   logic [7:0]    code_q, code_d;
   logic          rel_q, rel_d;
   logic          ext_q, ext_d;
   logic          err_q, err_d;
   logic          ovr_q, ovr_d;
   logic [TW-1:0] wd_q, wd_d;

   logic is_e0, is_f0, is_ign, in_prefix;

   always_comb begin
      is_e0     = (rx_data == 8'hE0);
      is_f0     = (rx_data == 8'hF0);
      in_prefix = (state_q == StBrk) || (state_q == StExt) || (state_q == StExtBrk);
      case (rx_data)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ign = 1'b1;
         default:                                                is_ign = 1'b0;
      endcase

      state_d = state_q;
      code_d  = code_q;
      rel_d   = rel_q;
      ext_d   = ext_q;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      wd_d    = '0;

      case (state_q)
         StIdle: begin
            if (rx_done_tick) begin
               if (is_e0) begin
                  state_d = StExt;
               end else if (is_f0) begin
                  state_d = StBrk;
               end else if (!is_ign) begin
                  state_d = StHold;
                  code_d  = rx_data;
                  rel_d   = 1'b0;
                  ext_d   = 1'b0;
               end
            end
         end
         StBrk, StExtBrk: begin
            if (rx_done_tick) begin
               if (is_e0 || is_f0) begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end else begin
                  state_d = StHold;
                  code_d  = rx_data;
                  rel_d   = 1'b1;
                  ext_d   = (state_q == StExtBrk);
               end
            end
         end
         StExt: begin
            if (rx_done_tick) begin
               if (is_f0) begin
                  state_d = StExtBrk;
               end else if (is_e0) begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end else begin
                  state_d = StHold;
                  code_d  = rx_data;
                  rel_d   = 1'b0;
                  ext_d   = 1'b1;
               end
            end
         end
         StHold: begin
            // A byte landing here is lost even when the ack frees us this cycle.
            ovr_d = rx_done_tick;
            if (key_ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Watchdog only runs between bytes of a prefix; a byte always wins over expiry.
      if (in_prefix && !rx_done_tick) begin
         if (wd_q == WdLast) begin
            state_d = StIdle;
            err_d   = 1'b1;
         end else begin
            wd_d = wd_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         code_q  <= 8'h00;
         rel_q   <= 1'b0;
         ext_q   <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         rel_q   <= rel_d;
         ext_q   <= ext_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         wd_q    <= wd_d;
      end
   end

   assign rx_en        = (state_q != StHold);
   assign key_valid    = (state_q == StHold);
   assign key_code     = code_q;
   assign key_release  = rel_q;
   assign key_ext      = ext_q;
   assign err_tick     = err_q;
   assign overrun_tick = ovr_q;

endmodule
